// File: rtl/uart_autobaud_detector.sv
// Recovers the UART bit period from a 0x55 sync character on rx.
// Publishes clocks-per-bit with lock/error strobes.
module uart_autobaud_detector #(
    parameter int unsigned CNT_W               = 20,
    parameter int unsigned MIN_CLK_PER_BIT     = 16,
    parameter int unsigned MAX_CLK_PER_BIT     = 20000,
    parameter int unsigned DEFAULT_CLK_PER_BIT = 625
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             rx,
    output logic [CNT_W-1:0] clk_per_bit,
    output logic             locked,
    output logic             lock_stb,
    output logic             err
);
    localparam int unsigned      TOT_W   = CNT_W + 3;
    localparam logic [TOT_W-1:0] C_MIN_I = TOT_W'(2 * MIN_CLK_PER_BIT);
    localparam logic [TOT_W-1:0] C_MAX_I = TOT_W'(2 * MAX_CLK_PER_BIT);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_MEAS, S_STOP, S_LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_sync2, r_hist;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_i1, w_i1_nxt;
    logic [TOT_W-1:0] r_total, w_total_nxt;
    logic [CNT_W-1:0] r_cpb, w_cpb_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_stb, w_stb_nxt;
    logic             r_err, w_err_nxt;

    logic             w_fall, w_rise, w_cnt_sat, w_bad_ival;
    logic [TOT_W-1:0] w_cnt_x, w_ival, w_i1_x, w_diff, w_win_lo, w_win_hi;

    assign w_fall     = r_hist & ~r_sync2;
    assign w_rise     = ~r_hist & r_sync2;
    assign w_cnt_sat  = &r_cnt;
    assign w_cnt_x    = TOT_W'(r_cnt);
    assign w_ival     = w_cnt_x + TOT_W'(1);
    assign w_i1_x     = TOT_W'(r_i1);
    assign w_diff     = (w_ival >= w_i1_x) ? (w_ival - w_i1_x) : (w_i1_x - w_ival);
    assign w_win_lo   = w_i1_x >> 2;
    assign w_win_hi   = (w_i1_x + (w_i1_x << 1)) >> 2;
    // First interval is range-checked; later ones must stay within I1/8 of it.
    assign w_bad_ival = (r_idx == 3'd1) ? ((w_ival < C_MIN_I) || (w_ival > C_MAX_I))
                                        : (w_diff > (w_i1_x >> 3));

    // rx synchroniser plus edge-history flop; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_i1     <= '0;
            r_total  <= '0;
            r_cpb    <= CNT_W'(DEFAULT_CLK_PER_BIT);
            r_locked <= 1'b0;
            r_stb    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_i1     <= w_i1_nxt;
            r_total  <= w_total_nxt;
            r_cpb    <= w_cpb_nxt;
            r_locked <= w_locked_nxt;
            r_stb    <= w_stb_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
        w_idx_nxt    = r_idx;
        w_i1_nxt     = r_i1;
        w_total_nxt  = r_total;
        w_cpb_nxt    = r_cpb;
        w_locked_nxt = r_locked;
        w_stb_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_ARMED;
            S_ARMED: begin
                if (w_fall) begin
                    w_state_nxt = S_MEAS;
                    w_idx_nxt   = 3'd1;
                    w_cnt_nxt   = '0;
                    w_total_nxt = '0;
                end
            end
            S_MEAS: begin
                // Timeout takes priority over a coincident fall.
                if (w_cnt_x > C_MAX_I) begin
                    w_state_nxt = S_ARMED;
                    w_err_nxt   = 1'b1;
                end else if (w_fall) begin
                    if (w_bad_ival) begin
                        w_state_nxt = S_ARMED;
                        w_err_nxt   = 1'b1;
                    end else begin
                        if (r_idx == 3'd1) begin
                            w_i1_nxt = CNT_W'(w_ival);
                        end
                        w_total_nxt = r_total + w_ival;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_cnt_nxt   = '0;
                        if (r_idx == 3'd4) begin
                            w_state_nxt = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_fall || (w_cnt_x > w_win_hi) || (w_rise && (w_cnt_x < w_win_lo))) begin
                    w_state_nxt = S_ARMED;
                    w_err_nxt   = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt  = S_LOCKED;
                    w_cpb_nxt    = CNT_W'((r_total + TOT_W'(4)) >> 3);
                    w_locked_nxt = 1'b1;
                    w_stb_nxt    = 1'b1;
                end
            end
            S_LOCKED: w_state_nxt = S_LOCKED;
            default:  w_state_nxt = S_IDLE;
        endcase
        // Disable overrides any lock or reject decided this cycle.
        if (!enable) begin
            w_state_nxt  = S_IDLE;
            w_locked_nxt = 1'b0;
            w_stb_nxt    = 1'b0;
            w_err_nxt    = 1'b0;
        end
    end

    assign clk_per_bit = r_cpb;
    assign locked      = r_locked;
    assign lock_stb    = r_stb;
    assign err         = r_err;

endmodule
